ras_spec_stage: RTL and testbench
=================================

# ras_spec_stage

Speculative return-address-stack stage with squash recovery, sitting between the fetch-side RAS front end and the next (committed) stage. It accepts push/pop actions from the predictor and shows speculative pushes on its scratchpad read port. It queues every accepted action in order and forwards each downstream on commit. Unlike a commit-only stage, it can discard all uncommitted actions in one cycle (branch mispredict) and restore its committed base address; it also reports queue occupancy, full and overflow.

## Interface
- DEPTH, 16: scratchpad entries and action-queue entries; power of two, ≥2; AW = $clog2(DEPTH).
- WIDTH, 32: return-address width.
- ADDR_WIDTH, 10: global RAS pointer width; ≥ AW.
- RESET_BASE, 0: base_addr value after reset.
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- trigger  in  1  new action valid this cycle.
- push_i, pop_i  in  1 each  action kind; both high = pop then push (replace top).
- data_i  in  WIDTH  pushed return address.
- addr_i  in  ADDR_WIDTH  RAS pointer after this action.
- commit  in  1  retire oldest queued action.
- squash  in  1  discard all uncommitted actions.
- act_valid_o  out  1  queue non-empty; push_o/pop_o/data_o/addr_o valid.
- push_o, pop_o, data_o, addr_o  out  1/1/WIDTH/ADDR_WIDTH  oldest queued action.
- rd_addr  in  ADDR_WIDTH  scratchpad read pointer.
- rd_data  out  WIDTH  scratchpad data, 1-cycle latency.
- valid  out  1  visible speculative push count ≠ 0.
- base_addr  out  ADDR_WIDTH  current speculative pointer.
- count_o  out  AW+1  queued actions.
- full_o  out  1  count_o == DEPTH.
- overflow_o  out  1  one-cycle pulse: trigger dropped because the queue was full.

## Operation
- Accept: acc = trigger & ~squash & (~full_o | (commit & act_valid_o)). A rejected trigger while full sets overflow_o next cycle. A trigger lost to squash does not set overflow_o.
- On acc: enqueue {data_i, addr_i, pop_i, push_i}. If push_i, write data_i to scratchpad[addr_i[AW-1:0]].
- Commit when queue empty: ignored. Otherwise dequeue and present the next entry.
- Counters (AW+1 bits, never wrap):
  - visible += acc&push_i; visible −= acc&pop_i&(visible≠0); visible −= c&push_o&(masked==0).
  - masked += acc&pop_i&(visible≠0); masked −= c&push_o&(masked≠0).
  - Here c = commit & act_valid_o. All terms use pre-update values.
- A pop with visible==0 passes through to the lower stage untouched.
- base_addr is combinational: addr_i when acc, else base_reg. base_reg <= base_addr.
- commit_base <= addr_o on c.
- Squash, evaluated after any same-cycle commit:
  - queue emptied; visible and masked cleared.
  - base_reg <= commit_base, or addr_o if c in the same cycle.
  - Scratchpad contents are not modified.
- Reset:
  - count, visible, masked = 0; act_valid_o, full_o, overflow_o, valid = 0.
  - base_reg = commit_base = RESET_BASE.
  - rd_data = 0 on the first cycle after reset.
  - push_o/pop_o = 0 while empty; data_o/addr_o are don't-care while empty.

## Timing
- Enqueue to act_valid_o: 1 cycle.
- Commit to next head visible: 1 cycle.
- rd_data: registered, 1 cycle after rd_addr.
- Read-during-write to the same index returns the new data.
- valid and count_o update 1 cycle after the causing event.
- Full queue with trigger+commit in the same cycle: trigger accepted, count unchanged, full_o stays 1.
- Squash+trigger: trigger dropped. Squash+commit: committed action is forwarded, the rest discarded.
- Reset mid-operation behaves as squash plus commit_base = RESET_BASE.

## Structure
- ras_pkg:
  - ras_action_t packed struct {data, addr, pop, push}, parameterised via package functions/localparams for WIDTH/ADDR_WIDTH.
  - localparam helper for AW.
- Sub-modules:
  - Scratchpad reuses ras_bram: one read port, one write port, RESOLVE_COLLIDE=1.
  - Action queue is one new sub-module, ras_action_fifo: DEPTH entries, count, full, empty, and flush input driven by squash.

## Test plan
- Reset, then 3 pushes (A1..A3, addr 1..3) → valid=1, count_o=3, base_addr=3, rd_addr=2 gives A2 next cycle.
- 2 pushes, 3 pops, 5 commits in order → pop_o sequence forwarded; visible ends 0, masked ends 0; third pop passed through with visible already 0.
- Fill 16 actions, trigger without commit → overflow_o pulses 1, count_o=16. Trigger+commit while full → accepted, count_o stays 16.
- Push/push/commit/push then squash → count_o=0, valid=0, base_addr = addr of first push; next trigger proceeds normally.
- Squash+commit+trigger in the same cycle → commit forwarded, trigger dropped, base_addr = committed addr_o.
- Reset asserted with 5 queued actions → all outputs at reset values next cycle, base_addr = RESET_BASE.

Source files
------------

// File: rtl/ras_pkg.sv
// ----------------------------------------------------------------------------
// ras_pkg
//   Shared types and sizing helpers for the speculative RAS stage.
//   Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package ras_pkg;

    localparam int RAS_WIDTH_DEF      = 32;
    localparam int RAS_ADDR_WIDTH_DEF = 10;

    // Reference layout of a queued action; the stage re-declares it with its
    // own parameter widths but keeps this exact field order.
    typedef struct packed {
        logic [RAS_WIDTH_DEF-1:0]      data;
        logic [RAS_ADDR_WIDTH_DEF-1:0] addr;
        logic                          pop;
        logic                          push;
    } ras_action_t;

    function automatic int ras_aw(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    function automatic int ras_action_w(input int width, input int addr_width);
        return width + addr_width + 2;
    endfunction

endpackage

`default_nettype wire

// File: rtl/ras_action_fifo.sv
// ----------------------------------------------------------------------------
// ras_action_fifo
//   In-order action queue with occupancy count and single-cycle flush.
//   Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module ras_action_fifo
    import ras_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int W     = 44,
    localparam int AW   = ras_aw(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          flush,
    input  logic          wr_en,
    input  logic [W-1:0]  wr_data,
    input  logic          rd_en,
    output logic [W-1:0]  rd_data,
    output logic [AW:0]   count,
    output logic          full,
    output logic          empty
);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          do_rd, do_wr;

    assign full  = (count_q == (AW+1)'(DEPTH));
    assign empty = (count_q == '0);

    // When full, a write is only legal alongside a read: the head slot is
    // consumed combinationally this cycle and refilled at the edge.
    always_comb begin
        do_rd    = rd_en & ~empty;
        do_wr    = wr_en & (~full | do_rd) & ~flush;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_wr) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (do_rd) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            count_d = count_q + {{AW{1'b0}}, do_wr} - {{AW{1'b0}}, do_rd};
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign rd_data = mem_q[rd_ptr_q];
    assign count   = count_q;

endmodule

`default_nettype wire

// File: rtl/ras_bram.sv
// ----------------------------------------------------------------------------
// ras_bram
//   Simple dual-port scratchpad, registered read, optional write-first bypass.
//   Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module ras_bram
    import ras_pkg::*;
#(
    parameter int DEPTH           = 16,
    parameter int WIDTH           = 32,
    parameter int RESOLVE_COLLIDE = 1,
    localparam int AW             = ras_aw(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rdata_q, rdata_d;
    logic             collide;

    generate
        if (RESOLVE_COLLIDE != 0) begin : g_collide
            assign collide = we && (waddr == raddr);
        end else begin : g_no_collide
            assign collide = 1'b0;
        end
    endgenerate

    always_comb begin
        rdata_d = collide ? wdata : mem_q[raddr];
    end

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata = rdata_q;

endmodule

`default_nettype wire

// File: rtl/ras_spec_stage.sv
// ----------------------------------------------------------------------------
// ras_spec_stage
//   Speculative RAS stage: queues push/pop actions until commit, squashes back
//   to the committed base pointer on mispredict.
//   Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module ras_spec_stage
    import ras_pkg::*;
#(
    parameter int DEPTH      = 16,
    parameter int WIDTH      = 32,
    parameter int ADDR_WIDTH = 10,
    parameter int RESET_BASE = 0,
    localparam int AW        = ras_aw(DEPTH)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  trigger,
    input  logic                  push_i,
    input  logic                  pop_i,
    input  logic [WIDTH-1:0]      data_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic                  commit,
    input  logic                  squash,
    output logic                  act_valid_o,
    output logic                  push_o,
    output logic                  pop_o,
    output logic [WIDTH-1:0]      data_o,
    output logic [ADDR_WIDTH-1:0] addr_o,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [WIDTH-1:0]      rd_data,
    output logic                  valid,
    output logic [ADDR_WIDTH-1:0] base_addr,
    output logic [AW:0]           count_o,
    output logic                  full_o,
    output logic                  overflow_o
);

    localparam int ACT_W = ras_action_w(WIDTH, ADDR_WIDTH);

    typedef struct packed {
        logic [WIDTH-1:0]      data;
        logic [ADDR_WIDTH-1:0] addr;
        logic                  pop;
        logic                  push;
    } act_t;

    act_t                  wr_act, head;
    logic [ACT_W-1:0]      head_raw;
    logic                  fifo_empty, fifo_full;
    logic                  acc, c;
    logic                  dec_pop, dec_cm;
    logic [AW+1:0]         vis_sum, vis_sub;
    logic [AW:0]           visible_q, visible_d;
    logic [AW:0]           masked_q, masked_d;
    logic [ADDR_WIDTH-1:0] base_reg_q, base_reg_d;
    logic [ADDR_WIDTH-1:0] commit_base_q, commit_base_d;
    logic                  overflow_q, overflow_d;
    logic                  rd_addr_unused;

    assign c      = commit & ~fifo_empty;
    assign acc    = trigger & ~squash & (~fifo_full | c);
    assign wr_act = '{data: data_i, addr: addr_i, pop: pop_i, push: push_i};
    assign head   = act_t'(head_raw);

    ras_action_fifo #(
        .DEPTH (DEPTH),
        .W     (ACT_W)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .flush   (squash),
        .wr_en   (acc),
        .wr_data (wr_act),
        .rd_en   (c),
        .rd_data (head_raw),
        .count   (count_o),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    ras_bram #(
        .DEPTH           (DEPTH),
        .WIDTH           (WIDTH),
        .RESOLVE_COLLIDE (1)
    ) u_scratch (
        .clk   (clk),
        .reset (reset),
        .we    (acc & push_i),
        .waddr (addr_i[AW-1:0]),
        .wdata (data_i),
        .raddr (rd_addr[AW-1:0]),
        .rdata (rd_data)
    );

    assign rd_addr_unused = ^rd_addr;

    always_comb begin
        dec_pop       = acc & pop_i & (visible_q != '0);
        dec_cm        = c & head.push & (masked_q == '0);
        vis_sum       = {1'b0, visible_q} + {{(AW+1){1'b0}}, acc & push_i};
        vis_sub       = {{(AW+1){1'b0}}, dec_pop} + {{(AW+1){1'b0}}, dec_cm};
        visible_d     = (vis_sum > vis_sub) ? (AW+1)'(vis_sum - vis_sub) : '0;
        masked_d      = masked_q + {{AW{1'b0}}, dec_pop}
                        - {{AW{1'b0}}, c & head.push & (masked_q != '0)};
        base_addr     = acc ? addr_i : base_reg_q;
        base_reg_d    = base_addr;
        commit_base_d = c ? head.addr : commit_base_q;
        overflow_d    = trigger & ~squash & fifo_full & ~c;
        // Squash acts after the same-cycle commit, so a retiring head becomes the new base.
        if (squash) begin
            visible_d  = '0;
            masked_d   = '0;
            base_reg_d = c ? head.addr : commit_base_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            visible_q     <= '0;
            masked_q      <= '0;
            base_reg_q    <= ADDR_WIDTH'(RESET_BASE);
            commit_base_q <= ADDR_WIDTH'(RESET_BASE);
            overflow_q    <= 1'b0;
        end else begin
            visible_q     <= visible_d;
            masked_q      <= masked_d;
            base_reg_q    <= base_reg_d;
            commit_base_q <= commit_base_d;
            overflow_q    <= overflow_d;
        end
    end

    assign act_valid_o = ~fifo_empty;
    assign push_o      = ~fifo_empty & head.push;
    assign pop_o       = ~fifo_empty & head.pop;
    assign data_o      = head.data;
    assign addr_o      = head.addr;
    assign valid       = (visible_q != '0);
    assign full_o      = fifo_full;
    assign overflow_o  = overflow_q;

endmodule

`default_nettype wire

// File: tb/tb_ras_spec_stage.sv
// ----------------------------------------------------------------------------
// tb_ras_spec_stage
//   Directed self-checking bench for ras_spec_stage.
//   Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_ras_spec_stage;

    logic        clk;
    logic        reset;
    logic        trigger, push_i, pop_i, commit, squash;
    logic [31:0] data_i;
    logic [9:0]  addr_i;
    logic        act_valid_o, push_o, pop_o;
    logic [31:0] data_o;
    logic [9:0]  addr_o;
    logic [9:0]  rd_addr;
    logic [31:0] rd_data;
    logic        valid;
    logic [9:0]  base_addr;
    logic [4:0]  count_o;
    logic        full_o, overflow_o;

    int errors = 0;
    int checks = 0;

    ras_spec_stage #(
        .DEPTH      (16),
        .WIDTH      (32),
        .ADDR_WIDTH (10),
        .RESET_BASE (0)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .trigger     (trigger),
        .push_i      (push_i),
        .pop_i       (pop_i),
        .data_i      (data_i),
        .addr_i      (addr_i),
        .commit      (commit),
        .squash      (squash),
        .act_valid_o (act_valid_o),
        .push_o      (push_o),
        .pop_o       (pop_o),
        .data_o      (data_o),
        .addr_o      (addr_o),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .valid       (valid),
        .base_addr   (base_addr),
        .count_o     (count_o),
        .full_o      (full_o),
        .overflow_o  (overflow_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic clear();
        trigger = 1'b0; push_i = 1'b0; pop_i = 1'b0;
        commit  = 1'b0; squash = 1'b0;
        data_i  = '0;   addr_i = '0;
    endtask

    task automatic act(input logic pu, input logic po, input logic [31:0] d,
                       input logic [9:0] a, input logic cm);
        trigger = 1'b1; push_i = pu; pop_i = po; data_i = d; addr_i = a; commit = cm;
        cycle();
        clear();
    endtask

    task automatic do_commit();
        commit = 1'b1;
        cycle();
        clear();
    endtask

    localparam logic [4:0] EXP_PUSH = 5'b00011;
    localparam logic [4:0] EXP_POP  = 5'b11100;

    initial begin
        logic [4:0] ep, eo;
        ep = EXP_PUSH;
        eo = EXP_POP;
        clear();
        rd_addr = '0;
        reset   = 1'b1;
        cycle();
        cycle();
        chk("rst_count",    64'(count_o), 64'd0);
        chk("rst_actvalid", 64'(act_valid_o), 64'd0);
        chk("rst_valid",    64'(valid), 64'd0);
        chk("rst_full",     64'(full_o), 64'd0);
        chk("rst_overflow", 64'(overflow_o), 64'd0);
        chk("rst_base",     64'(base_addr), 64'd0);
        chk("rst_rddata",   64'(rd_data), 64'd0);
        chk("rst_push_o",   64'(push_o), 64'd0);
        reset = 1'b0;
        cycle();

        // Three pushes, scratchpad readback
        act(1'b1, 1'b0, 32'hA000_0001, 10'd1, 1'b0);
        act(1'b1, 1'b0, 32'hA000_0002, 10'd2, 1'b0);
        trigger = 1'b1; push_i = 1'b1; data_i = 32'hA000_0003; addr_i = 10'd3;
        #1;
        chk("t1_base_comb", 64'(base_addr), 64'd3);
        cycle();
        clear();
        chk("t1_count",  64'(count_o), 64'd3);
        chk("t1_valid",  64'(valid), 64'd1);
        chk("t1_base",   64'(base_addr), 64'd3);
        chk("t1_head",   64'(data_o), 64'hA000_0001);
        chk("t1_push_o", 64'(push_o), 64'd1);
        rd_addr = 10'd2;
        cycle();
        chk("t1_rddata", 64'(rd_data), 64'hA000_0002);
        rd_addr = '0;
        do_commit();
        chk("t1_head2",  64'(data_o), 64'hA000_0002);
        chk("t1_count2", 64'(count_o), 64'd2);
        do_commit();
        chk("t1_addr3",  64'(addr_o), 64'd3);
        do_commit();
        chk("t1_empty",  64'(act_valid_o), 64'd0);
        chk("t1_valid0", 64'(valid), 64'd0);

        // Two pushes, three pops; third pop passes through
        act(1'b1, 1'b0, 32'hB1, 10'd4, 1'b0);
        act(1'b1, 1'b0, 32'hB2, 10'd5, 1'b0);
        act(1'b0, 1'b1, 32'h0,  10'd4, 1'b0);
        act(1'b0, 1'b1, 32'h0,  10'd3, 1'b0);
        act(1'b0, 1'b1, 32'h0,  10'd2, 1'b0);
        chk("t2_count", 64'(count_o), 64'd5);
        chk("t2_valid", 64'(valid), 64'd0);
        chk("t2_base",  64'(base_addr), 64'd2);
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("t2_push_o%0d", i), 64'(push_o), 64'(ep[i]));
            chk($sformatf("t2_pop_o%0d", i),  64'(pop_o),  64'(eo[i]));
            do_commit();
        end
        chk("t2_count0", 64'(count_o), 64'd0);
        chk("t2_pop_o_empty", 64'(pop_o), 64'd0);
        act(1'b1, 1'b0, 32'hC0, 10'd3, 1'b0);
        chk("t2_valid_push", 64'(valid), 64'd1);
        do_commit();
        chk("t2_valid_after", 64'(valid), 64'd0);

        // Fill, overflow, trigger+commit while full
        for (int i = 0; i < 16; i++) begin
            act(1'b1, 1'b0, 32'h100 + 32'(i), 10'(i), 1'b0);
        end
        chk("t3_count16", 64'(count_o), 64'd16);
        chk("t3_full",    64'(full_o), 64'd1);
        chk("t3_base15",  64'(base_addr), 64'd15);
        act(1'b1, 1'b0, 32'hDEAD, 10'd9, 1'b0);
        chk("t3_overflow", 64'(overflow_o), 64'd1);
        chk("t3_count_ov", 64'(count_o), 64'd16);
        chk("t3_base_ov",  64'(base_addr), 64'd15);
        cycle();
        chk("t3_overflow_drop", 64'(overflow_o), 64'd0);
        act(1'b1, 1'b0, 32'h55, 10'd7, 1'b1);
        chk("t3_count_tc", 64'(count_o), 64'd16);
        chk("t3_full_tc",  64'(full_o), 64'd1);
        chk("t3_ovf_tc",   64'(overflow_o), 64'd0);
        chk("t3_head_tc",  64'(data_o), 64'h101);
        chk("t3_base_tc",  64'(base_addr), 64'd7);
        for (int i = 0; i < 15; i++) begin
            do_commit();
        end
        chk("t3_last", 64'(data_o), 64'h55);
        do_commit();
        chk("t3_drained", 64'(count_o), 64'd0);
        chk("t3_valid0",  64'(valid), 64'd0);

        // Squash restores committed base
        act(1'b1, 1'b0, 32'hD1, 10'd20, 1'b0);
        act(1'b1, 1'b0, 32'hD2, 10'd21, 1'b0);
        do_commit();
        act(1'b1, 1'b0, 32'hD3, 10'd22, 1'b0);
        squash = 1'b1;
        cycle();
        clear();
        chk("t4_count", 64'(count_o), 64'd0);
        chk("t4_valid", 64'(valid), 64'd0);
        chk("t4_actv",  64'(act_valid_o), 64'd0);
        chk("t4_base",  64'(base_addr), 64'd20);
        rd_addr = 10'd30;
        act(1'b1, 1'b0, 32'hE0, 10'd30, 1'b0);
        chk("t4_rdw",    64'(rd_data), 64'hE0);
        rd_addr = '0;
        chk("t4_count1", 64'(count_o), 64'd1);
        chk("t4_valid1", 64'(valid), 64'd1);
        chk("t4_base30", 64'(base_addr), 64'd30);
        chk("t4_head",   64'(data_o), 64'hE0);
        do_commit();

        // Squash + commit + trigger together
        act(1'b1, 1'b0, 32'hF1, 10'd40, 1'b0);
        act(1'b1, 1'b0, 32'hF2, 10'd41, 1'b0);
        trigger = 1'b1; push_i = 1'b1; data_i = 32'h6; addr_i = 10'd50;
        commit = 1'b1; squash = 1'b1;
        #1;
        chk("t5_base_comb", 64'(base_addr), 64'd41);
        chk("t5_fwd_head",  64'(data_o), 64'hF1);
        cycle();
        clear();
        chk("t5_count", 64'(count_o), 64'd0);
        chk("t5_valid", 64'(valid), 64'd0);
        chk("t5_ovf",   64'(overflow_o), 64'd0);
        chk("t5_base",  64'(base_addr), 64'd40);
        cycle();
        chk("t5_base_hold", 64'(base_addr), 64'd40);

        // Reset with queued actions
        for (int i = 0; i < 5; i++) begin
            act(1'b1, 1'b0, 32'h70 + 32'(i), 10'd60 + 10'(i), 1'b0);
        end
        chk("t6_count5", 64'(count_o), 64'd5);
        reset = 1'b1;
        cycle();
        chk("t6_count", 64'(count_o), 64'd0);
        chk("t6_actv",  64'(act_valid_o), 64'd0);
        chk("t6_valid", 64'(valid), 64'd0);
        chk("t6_full",  64'(full_o), 64'd0);
        chk("t6_ovf",   64'(overflow_o), 64'd0);
        chk("t6_base",  64'(base_addr), 64'd0);
        chk("t6_rd",    64'(rd_data), 64'd0);
        chk("t6_push_o", 64'(push_o), 64'd0);
        reset = 1'b0;
        cycle();
        act(1'b1, 1'b0, 32'h99, 10'd5, 1'b0);
        chk("t6_post_count", 64'(count_o), 64'd1);
        chk("t6_post_base",  64'(base_addr), 64'd5);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
